// File: rtl/axis_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : axis_rr_arbiter_if
//  Description : Signal bundle for axis_rr_arbiter. Carries the NUM_STREAMS
//                input AXI-Stream channels (flattened, stream i in bit i /
//                data slice [i*DW +: DW]) and the single arbitrated output
//                channel with its source index (tid).
//                  master : the arbiter side (drives input readys and the
//                           output beat)
//                  slave  : the environment side (producers and sink)
//  Revision    : 1.0 - initial release
// ============================================================================
interface axis_rr_arbiter_if #(
    parameter int AXIS_BYTES  = 1,
    parameter int NUM_STREAMS = 4
);
    localparam int c_DW  = AXIS_BYTES * 8;
    localparam int c_IDW = $clog2(NUM_STREAMS);

    logic [NUM_STREAMS-1:0]      axis_i_tready;
    logic [NUM_STREAMS-1:0]      axis_i_tvalid;
    logic [NUM_STREAMS-1:0]      axis_i_tlast;
    logic [NUM_STREAMS*c_DW-1:0] axis_i_tdata;

    logic                        axis_o_tready;
    logic                        axis_o_tvalid;
    logic                        axis_o_tlast;
    logic [c_DW-1:0]             axis_o_tdata;
    logic [c_IDW-1:0]            axis_o_tid;

    modport master (
        output axis_i_tready,
        input  axis_i_tvalid,
        input  axis_i_tlast,
        input  axis_i_tdata,
        input  axis_o_tready,
        output axis_o_tvalid,
        output axis_o_tlast,
        output axis_o_tdata,
        output axis_o_tid
    );

    modport slave (
        input  axis_i_tready,
        output axis_i_tvalid,
        output axis_i_tlast,
        output axis_i_tdata,
        output axis_o_tready,
        input  axis_o_tvalid,
        input  axis_o_tlast,
        input  axis_o_tdata,
        input  axis_o_tid
    );
endinterface
`default_nettype wire

// File: rtl/axis_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : axis_rr_arbiter
//  Description : Packet-level round-robin arbiter sharing one AXI-Stream
//                output between NUM_STREAMS inputs. A grant is held from the
//                first beat of a packet until its tlast beat is accepted, so
//                packets never interleave. The output is a single register
//                stage that can be drained and reloaded in the same cycle.
//  Ports       : clk    - rising-edge clock
//                sreset - synchronous reset, active high
//                axis   - axis_rr_arbiter_if.master bundle:
//                         axis_i_* per-stream inputs (ready driven here),
//                         axis_o_* registered output beat plus source tid
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_rr_arbiter #(
    parameter int AXIS_BYTES  = 1,
    parameter int NUM_STREAMS = 4
) (
    input  logic              clk,
    input  logic              sreset,
    axis_rr_arbiter_if.master axis
);
    localparam int c_DW  = AXIS_BYTES * 8;
    localparam int c_IDW = $clog2(NUM_STREAMS);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                 r_state;
    logic [c_IDW-1:0]       r_grant;
    logic [c_IDW-1:0]       r_last_grant;
    logic                   r_o_tvalid;
    logic                   r_o_tlast;
    logic [c_DW-1:0]        r_o_tdata;
    logic [c_IDW-1:0]       r_o_tid;

    logic                   w_reg_ready;
    logic                   w_any_req;
    logic                   w_sel_valid;
    logic                   w_sel_last;
    logic [c_DW-1:0]        w_sel_data;
    logic                   w_load;
    logic [NUM_STREAMS-1:0] w_tready;
    logic [c_IDW-1:0]       w_winner;
    logic [c_IDW-1:0]       w_cand;

    // Output register has room when it is empty or being drained this cycle.
    assign w_reg_ready = !r_o_tvalid || axis.axis_o_tready;
    assign w_any_req   = |axis.axis_i_tvalid;

    // Round-robin search starting just after the last grant. Candidates are
    // visited from farthest to nearest so the final overwrite is the first
    // requesting stream in wrap-around order.
    always_comb begin
        w_winner = r_last_grant;
        w_cand   = '0;
        for (int k = NUM_STREAMS; k >= 1; k--) begin
            if (int'(r_last_grant) + k >= NUM_STREAMS) begin
                w_cand = c_IDW'(int'(r_last_grant) + k - NUM_STREAMS);
            end else begin
                w_cand = c_IDW'(int'(r_last_grant) + k);
            end
            if (axis.axis_i_tvalid[w_cand]) begin
                w_winner = w_cand;
            end
        end
    end

    // Select the granted stream and steer ready to it alone.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        w_tready    = '0;
        for (int i = 0; i < NUM_STREAMS; i++) begin
            if (r_grant == c_IDW'(i)) begin
                w_sel_valid = axis.axis_i_tvalid[i];
                w_sel_last  = axis.axis_i_tlast[i];
                w_sel_data  = axis.axis_i_tdata[i*c_DW +: c_DW];
                w_tready[i] = (r_state == ST_LOCKED) && w_reg_ready;
            end
        end
    end

    assign w_load = (r_state == ST_LOCKED) && w_sel_valid && w_reg_ready;

    // Arbitration state and output-valid flag.
    always_ff @(posedge clk) begin
        if (sreset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= c_IDW'(NUM_STREAMS - 1);
            r_o_tvalid   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_grant      <= w_winner;
                        r_last_grant <= w_winner;
                        r_state      <= ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    // Requests raised during this cycle are seen in the
                    // following IDLE cycle.
                    if (w_load && w_sel_last) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_load) begin
                r_o_tvalid <= 1'b1;
            end else if (axis.axis_o_tready) begin
                r_o_tvalid <= 1'b0;
            end
        end
    end

    // Payload needs no reset; it is qualified by r_o_tvalid.
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_o_tdata <= w_sel_data;
            r_o_tlast <= w_sel_last;
            r_o_tid   <= r_grant;
        end
    end

    assign axis.axis_i_tready = w_tready;
    assign axis.axis_o_tvalid = r_o_tvalid;
    assign axis.axis_o_tlast  = r_o_tlast;
    assign axis.axis_o_tdata  = r_o_tdata;
    assign axis.axis_o_tid    = r_o_tid;

endmodule
`default_nettype wire

// File: tb/tb_axis_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_rr_arbiter
//  Description : Self-checking bench for axis_rr_arbiter. Packets are staged
//                per stream, a reference model derives the expected output
//                beat order from the round-robin rules and queues it, and a
//                separate monitor pops and compares every accepted output
//                beat. Saturated phases also check cycle-exact timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_rr_arbiter;
    localparam int AXIS_BYTES  = 1;
    localparam int NUM_STREAMS = 4;
    localparam int DW          = AXIS_BYTES * 8;
    localparam int IDW         = $clog2(NUM_STREAMS);

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic          first;
    } beat_t;

    typedef struct {
        logic [DW-1:0]  data;
        logic           last;
        logic [IDW-1:0] tid;
    } exp_t;

    logic clk    = 1'b0;
    logic sreset = 1'b1;

    axis_rr_arbiter_if #(.AXIS_BYTES(AXIS_BYTES), .NUM_STREAMS(NUM_STREAMS)) bus ();

    axis_rr_arbiter #(.AXIS_BYTES(AXIS_BYTES), .NUM_STREAMS(NUM_STREAMS)) dut (
        .clk    (clk),
        .sreset (sreset),
        .axis   (bus)
    );

    always #5 clk = ~clk;

    beat_t drv_q   [NUM_STREAMS][$];
    int    stg     [NUM_STREAMS][$];
    exp_t  exp_q   [$];
    int    ord_tid [$];
    int    ord_len [$];
    logic [NUM_STREAMS-1:0] vld = '0;

    int checks   = 0;
    int errors   = 0;
    int gap_pct  = 0;
    int rdy_mode = 0;
    int rdy_pct  = 100;
    int mdl_last = NUM_STREAMS - 1;

    task automatic check(input string name, input bit ok, input string detail);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    function automatic bit drv_empty();
        for (int s = 0; s < NUM_STREAMS; s++) begin
            if (drv_q[s].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Turn staged packet lengths into beats and compute the expected output
    // sequence: repeatedly pick the first stream after the previous winner
    // that still has a packet, and emit that whole packet.
    task automatic commit();
        int    left [NUM_STREAMS];
        int    pos  [NUM_STREAMS];
        int    total, w, c, len;
        beat_t b;
        exp_t  e;
        ord_tid.delete();
        ord_len.delete();
        total = 0;
        for (int s = 0; s < NUM_STREAMS; s++) begin
            left[s] = stg[s].size();
            pos[s]  = 0;
            total  += left[s];
            for (int p = 0; p < left[s]; p++) begin
                len = stg[s][p];
                for (int j = 0; j < len; j++) begin
                    b.data  = DW'($urandom);
                    b.last  = (j == len - 1);
                    b.first = (j == 0);
                    drv_q[s].push_back(b);
                end
            end
            stg[s].delete();
        end
        for (int n = 0; n < total; n++) begin
            w = -1;
            for (int k = 1; k <= NUM_STREAMS; k++) begin
                c = (mdl_last + k) % NUM_STREAMS;
                if (w < 0 && left[c] > 0) w = c;
            end
            len = 0;
            do begin
                e.data = drv_q[w][pos[w]].data;
                e.last = drv_q[w][pos[w]].last;
                e.tid  = IDW'(w);
                exp_q.push_back(e);
                pos[w]++;
                len++;
            end while (!e.last);
            ord_tid.push_back(w);
            ord_len.push_back(len);
            left[w]--;
            mdl_last = w;
        end
    endtask

    // Drive inputs at the falling edge, then record handshakes just after.
    // stop_after > 0 returns once that many input beats have been accepted.
    task automatic run_phase(input bit timed, input int stop_after);
        int cyc, acc, t, bad_ov, bad_tr;
        bit done, eov;
        logic [NUM_STREAMS-1:0] etr;
        logic [NUM_STREAMS-1:0] tr_hist [$];
        bit ov_hist [$];
        cyc  = 0;
        acc  = 0;
        done = 1'b0;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            for (int s = 0; s < NUM_STREAMS; s++) begin
                if (drv_q[s].size() == 0) begin
                    vld[s] = 1'b0;
                    bus.axis_i_tlast[s] = 1'b0;
                    bus.axis_i_tdata[s*DW +: DW] = '0;
                end else begin
                    if (!vld[s]) vld[s] = drv_q[s][0].first || ($urandom_range(99) >= gap_pct);
                    bus.axis_i_tlast[s] = drv_q[s][0].last;
                    bus.axis_i_tdata[s*DW +: DW] = drv_q[s][0].data;
                end
            end
            bus.axis_i_tvalid = vld;
            case (rdy_mode)
                0:       bus.axis_o_tready = 1'b1;
                1:       bus.axis_o_tready = ($urandom_range(99) < rdy_pct);
                default: bus.axis_o_tready = (cyc % 3 == 0);
            endcase
            #1;
            tr_hist.push_back(bus.axis_i_tready);
            ov_hist.push_back(bus.axis_o_tvalid);
            for (int s = 0; s < NUM_STREAMS; s++) begin
                if (vld[s] && bus.axis_i_tready[s]) begin
                    void'(drv_q[s].pop_front());
                    vld[s] = 1'b0;
                    acc++;
                end
            end
            cyc++;
            if (stop_after > 0 && acc >= stop_after) return;
            done = drv_empty() && (exp_q.size() == 0) && !bus.axis_o_tvalid;
        end
        if (!done) begin
            check("phase_timeout", 1'b0, $sformatf("got %0d beats pending, want 0", exp_q.size()));
            for (int s = 0; s < NUM_STREAMS; s++) drv_q[s].delete();
            exp_q.delete();
            vld = '0;
            return;
        end
        if (timed) begin
            bad_ov = 0;
            bad_tr = 0;
            for (int c = 0; c < cyc; c++) begin
                eov = 1'b0;
                etr = '0;
                t   = 2;
                for (int p = 0; p < ord_len.size(); p++) begin
                    if (c >= t && c < t + ord_len[p]) eov = 1'b1;
                    if (c >= t - 1 && c < t - 1 + ord_len[p]) etr = NUM_STREAMS'(1) << ord_tid[p];
                    t += ord_len[p] + 1;
                end
                if (ov_hist[c] != eov) bad_ov++;
                if (tr_hist[c] !== etr) bad_tr++;
            end
            t = 2;
            for (int p = 0; p < ord_len.size(); p++) t += ord_len[p] + 1;
            check("timing_o_tvalid", bad_ov == 0, $sformatf("got %0d wrong cycles, want 0", bad_ov));
            check("timing_i_tready", bad_tr == 0, $sformatf("got %0d wrong cycles, want 0", bad_tr));
            check("timing_length", cyc == t, $sformatf("got %0d cycles, want %0d", cyc, t));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        sreset = 1'b1;
        vld = '0;
        bus.axis_i_tvalid = '0;
        bus.axis_i_tlast  = '0;
        bus.axis_o_tready = 1'b1;
        for (int s = 0; s < NUM_STREAMS; s++) drv_q[s].delete();
        exp_q.delete();
        mdl_last = NUM_STREAMS - 1;
        @(negedge clk);
        sreset = 1'b0;
        #1;
        check("reset_o_tvalid", bus.axis_o_tvalid == 1'b0, $sformatf("got %0b, want 0", bus.axis_o_tvalid));
        check("reset_i_tready", bus.axis_i_tready == '0, $sformatf("got %b, want 0", bus.axis_i_tready));
    endtask

    // Monitor: compares each accepted output beat against the queued model.
    logic           prev_stall = 1'b0;
    logic [DW-1:0]  prev_data;
    logic           prev_last;
    logic [IDW-1:0] prev_tid;
    exp_t           mon_e;

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (sreset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_stable",
                          bus.axis_o_tvalid && bus.axis_o_tdata == prev_data &&
                          bus.axis_o_tlast == prev_last && bus.axis_o_tid == prev_tid,
                          $sformatf("got v=%0b d=%02h l=%0b id=%0d, want v=1 d=%02h l=%0b id=%0d",
                                    bus.axis_o_tvalid, bus.axis_o_tdata, bus.axis_o_tlast,
                                    bus.axis_o_tid, prev_data, prev_last, prev_tid));
                end
                if (bus.axis_o_tvalid && !bus.axis_o_tready) begin
                    check("tready_while_stalled", bus.axis_i_tready == '0,
                          $sformatf("got %b, want 0", bus.axis_i_tready));
                end
                check("tready_onehot", $countones(bus.axis_i_tready) <= 1,
                      $sformatf("got %b, want at most one bit", bus.axis_i_tready));
                if (bus.axis_o_tvalid && bus.axis_o_tready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 1'b0,
                              $sformatf("got d=%02h id=%0d, want no beat", bus.axis_o_tdata, bus.axis_o_tid));
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("out_beat",
                              bus.axis_o_tdata == mon_e.data && bus.axis_o_tlast == mon_e.last &&
                              bus.axis_o_tid == mon_e.tid,
                              $sformatf("got d=%02h l=%0b id=%0d, want d=%02h l=%0b id=%0d",
                                        bus.axis_o_tdata, bus.axis_o_tlast, bus.axis_o_tid,
                                        mon_e.data, mon_e.last, mon_e.tid));
                    end
                end
                prev_stall = bus.axis_o_tvalid && !bus.axis_o_tready;
                prev_data  = bus.axis_o_tdata;
                prev_last  = bus.axis_o_tlast;
                prev_tid   = bus.axis_o_tid;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no end of test, want completion");
        $fatal(1, "simulation timeout");
    end

    initial begin
        int  np, any;
        bit  timed;
        bus.axis_i_tvalid = '0;
        bus.axis_i_tlast  = '0;
        bus.axis_i_tdata  = '0;
        bus.axis_o_tready = 1'b1;
        do_reset();

        // Single 3-beat packet from stream 2, sink always ready.
        gap_pct  = 0;
        rdy_mode = 0;
        stg[2].push_back(3);
        commit();
        run_phase(1'b1, 0);

        // Streams 0 and 1 alternate 2-beat packets.
        for (int i = 0; i < 3; i++) begin
            stg[0].push_back(2);
            stg[1].push_back(2);
        end
        commit();
        run_phase(1'b1, 0);

        // All four request right after reset: order 0,1,2,3,0.
        do_reset();
        stg[0].push_back(2);
        stg[0].push_back(1);
        stg[1].push_back(3);
        stg[2].push_back(1);
        stg[3].push_back(2);
        commit();
        run_phase(1'b1, 0);

        // 4-beat packet from stream 1 with sink ready toggling 1,0,0.
        rdy_mode = 2;
        stg[1].push_back(4);
        commit();
        run_phase(1'b0, 0);

        // One-beat packets from streams 0 and 3.
        rdy_mode = 0;
        for (int i = 0; i < 3; i++) begin
            stg[0].push_back(1);
            stg[3].push_back(1);
        end
        commit();
        run_phase(1'b1, 0);

        // Reset during beat 2 of a 5-beat packet; arbitration restarts at 0.
        stg[1].push_back(5);
        commit();
        run_phase(1'b0, 2);
        do_reset();
        stg[0].push_back(2);
        stg[3].push_back(2);
        commit();
        run_phase(1'b1, 0);

        // Randomized phases: stream subsets, lengths, gaps and backpressure.
        for (int ph = 0; ph < 40; ph++) begin
            any = 0;
            for (int s = 0; s < NUM_STREAMS; s++) begin
                if ($urandom_range(1) == 1) begin
                    np = $urandom_range(1, 3);
                    for (int p = 0; p < np; p++) stg[s].push_back($urandom_range(1, 6));
                    any = 1;
                end
            end
            if (any == 0) stg[$urandom_range(NUM_STREAMS-1)].push_back($urandom_range(1, 6));
            gap_pct = ($urandom_range(1) == 1) ? 0 : $urandom_range(10, 50);
            if ($urandom_range(2) == 0) begin
                rdy_mode = 0;
            end else begin
                rdy_mode = 1;
                rdy_pct  = $urandom_range(30, 90);
            end
            timed = (rdy_mode == 0) && (gap_pct == 0);
            commit();
            run_phase(timed, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
